// File: rtl/drum_pkg.sv
// Shared definitions for the drum machine tone stage: voice indices, the
// half-period note table and helpers for voice-mask arithmetic.
package drum_pkg;

   localparam int NUM_VOICES = 5;
   localparam int HP_W       = 17;

   // Voice index 0 is A; it sits in the MSB of the {A,B,C,D,E} voice vector.
   typedef logic [2:0] voice_idx_t;
   localparam voice_idx_t V_A = 3'd0;
   localparam voice_idx_t V_B = 3'd1;
   localparam voice_idx_t V_C = 3'd2;
   localparam voice_idx_t V_D = 3'd3;
   localparam voice_idx_t V_E = 3'd4;

   localparam logic [HP_W-1:0] HP_A = 17'd95557;  // C5
   localparam logic [HP_W-1:0] HP_B = 17'd85131;  // D5
   localparam logic [HP_W-1:0] HP_C = 17'd75843;  // E5
   localparam logic [HP_W-1:0] HP_D = 17'd63776;  // G5
   localparam logic [HP_W-1:0] HP_E = 17'd56818;  // A5

   typedef enum logic {S_IDLE, S_PLAY} tone_state_t;

   function automatic logic [HP_W-1:0] hp_lookup(input voice_idx_t idx);
      case (idx)
         V_A:     hp_lookup = HP_A;
         V_B:     hp_lookup = HP_B;
         V_C:     hp_lookup = HP_C;
         V_D:     hp_lookup = HP_D;
         V_E:     hp_lookup = HP_E;
         default: hp_lookup = HP_A;
      endcase
   endfunction

   function automatic logic [NUM_VOICES-1:0] voice_onehot(input voice_idx_t idx);
      voice_onehot = {1'b1, {(NUM_VOICES-1){1'b0}}} >> idx;
   endfunction

   function automatic logic multi_voice(input logic [NUM_VOICES-1:0] mask);
      multi_voice = (mask & (mask - 1'b1)) != '0;
   endfunction

   // Highest-priority set voice; the scan runs E..A so A wins last.
   function automatic voice_idx_t first_voice(input logic [NUM_VOICES-1:0] mask);
      first_voice = V_A;
      for (int i = NUM_VOICES - 1; i >= 0; i--)
         if (mask[NUM_VOICES - 1 - i]) first_voice = voice_idx_t'(i);
   endfunction

   // Next set voice after cur in A..E order with wrap; cur itself if it is the only one.
   function automatic voice_idx_t next_voice(input logic [NUM_VOICES-1:0] mask,
                                             input voice_idx_t cur);
      int idx;
      next_voice = cur;
      for (int k = NUM_VOICES - 1; k >= 1; k--) begin
         idx = (int'(cur) + k) % NUM_VOICES;
         if (mask[NUM_VOICES - 1 - idx]) next_voice = voice_idx_t'(idx);
      end
   endfunction

endpackage

// File: rtl/drum_voice_tone_gen_tone_divider.sv
// Phase counter and square-wave toggle; the half period is captured only at
// clear and at each toggle so a changing input never shortens a running half.
module tone_divider #(
   parameter int HP_W = drum_pkg::HP_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            enable,
   input  logic            clear,
   input  logic [HP_W-1:0] half_period,
   output logic            note_clk
);

   logic [HP_W-1:0] phase;
   logic [HP_W-1:0] hp_reg;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         phase    <= '0;
         hp_reg   <= '0;
         note_clk <= 1'b0;
      end else if (clear) begin
         phase    <= '0;
         hp_reg   <= half_period;
         note_clk <= 1'b0;
      end else if (enable) begin
         if (phase == hp_reg - HP_W'(1)) begin
            phase    <= '0;
            hp_reg   <= half_period;
            note_clk <= ~note_clk;
         end else begin
            phase <= phase + HP_W'(1);
         end
      end
   end

endmodule

// File: rtl/drum_voice_tone_gen.sv
// Tone stage of the drum machine: turns per-step voice bits into a gated
// square-wave NOTE_CLK, with a per-step gate length and an arpeggio across voices.
module drum_voice_tone_gen #(
   parameter int HP_W         = drum_pkg::HP_W,
   parameter int GATE_W       = 24,
   parameter int GATE_CYCLES  = 15_000_000,
   parameter int ARP_CYCLES   = 2_000_000,
   parameter int OCTAVE_SHIFT = 0            // fixed transpose up by whole octaves
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       STEP_EN,
   input  logic [4:0] VOICE,
   input  logic       OCTAVE_UP,
   output logic       NOTE_CLK,
   output logic       GATE,
   output logic [4:0] ACTIVE_VOICE
);

   import drum_pkg::*;

   tone_state_t       state;
   logic [4:0]        mask;
   voice_idx_t        slot;
   voice_idx_t        slot_sel;
   logic [GATE_W-1:0] gate_cnt;
   logic [GATE_W-1:0] arp_cnt;
   logic [HP_W-1:0]   half_period;
   logic              start, stop, expire, advance, div_clear;

   // Priority: a step wins over gate expiry, and gate expiry wins over an arpeggio advance.
   always_comb begin
      // NOTE: slot_sel gets its default before any branch so no path infers a latch.
      slot_sel = slot;
      start    = STEP_EN && (VOICE != '0);
      stop     = (state == S_PLAY) && STEP_EN && (VOICE == '0);
      expire   = (state == S_PLAY) && !STEP_EN && (GATE_CYCLES != 0) &&
                 (gate_cnt == GATE_W'(1));
      advance  = (state == S_PLAY) && !STEP_EN && !expire && multi_voice(mask) &&
                 (arp_cnt == GATE_W'(1));
      if (start)        slot_sel = first_voice(VOICE);
      else if (advance) slot_sel = next_voice(mask, slot);
      half_period = HP_W'(hp_lookup(slot_sel) >> (OCTAVE_SHIFT + int'(OCTAVE_UP)));
      div_clear   = start || stop || expire || advance;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state        <= S_IDLE;
         // NOTE: the latched mask is control state, so it is reset along with the counters.
         mask         <= '0;
         slot         <= V_A;
         gate_cnt     <= '0;
         arp_cnt      <= '0;
         GATE         <= 1'b0;
         ACTIVE_VOICE <= '0;
      end else if (start) begin
         state        <= S_PLAY;
         mask         <= VOICE;
         slot         <= slot_sel;
         gate_cnt     <= GATE_W'(GATE_CYCLES);
         arp_cnt      <= GATE_W'(ARP_CYCLES);
         GATE         <= 1'b1;
         ACTIVE_VOICE <= voice_onehot(slot_sel);
      end else begin
         case (state)
            S_IDLE: state <= S_IDLE;
            S_PLAY: begin
               if (stop || expire) begin
                  state        <= S_IDLE;
                  mask         <= '0;
                  gate_cnt     <= '0;
                  arp_cnt      <= '0;
                  GATE         <= 1'b0;
                  ACTIVE_VOICE <= '0;
               end else begin
                  if (GATE_CYCLES != 0) gate_cnt <= gate_cnt - GATE_W'(1);
                  if (advance) begin
                     arp_cnt      <= GATE_W'(ARP_CYCLES);
                     slot         <= slot_sel;
                     ACTIVE_VOICE <= voice_onehot(slot_sel);
                  end else if (multi_voice(mask)) begin
                     arp_cnt <= arp_cnt - GATE_W'(1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   tone_divider #(.HP_W(HP_W)) u_divider (
      .CLK         (CLK),
      .RESET       (RESET),
      .enable      (state == S_PLAY),
      .clear       (div_clear),
      .half_period (half_period),
      .note_clk    (NOTE_CLK)
   );

endmodule

// File: tb/tb_drum_voice_tone_gen.sv
// Directed bench for drum_voice_tone_gen; pitch transposed 8 octaves up and gate/arp
// lengths scaled down so every note, slot and gate edge fits a short run.
`timescale 1ns/1ps
module tb_drum_voice_tone_gen;

   localparam int GATE_T = 4000;
   localparam int ARP_T  = 2000;
   // Table entries >> 8 (and >> 9 for A with OCTAVE_UP), worked out by hand.
   localparam int HP_A8 = 373;
   localparam int HP_B8 = 332;
   localparam int HP_C8 = 296;
   localparam int HP_D8 = 249;
   localparam int HP_E8 = 221;
   localparam int HP_A9 = 186;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       STEP_EN;
   logic [4:0] VOICE;
   logic       OCTAVE_UP;
   logic       note1, gate1, note2, gate2;
   logic [4:0] av1, av2;

   int n_checks = 0;
   int n_errors = 0;
   int idx = 0;

   always #5 CLK = ~CLK;

   drum_voice_tone_gen #(.GATE_CYCLES(GATE_T), .ARP_CYCLES(ARP_T), .OCTAVE_SHIFT(8)) dut (
      .CLK(CLK), .RESET(RESET), .STEP_EN(STEP_EN), .VOICE(VOICE), .OCTAVE_UP(OCTAVE_UP),
      .NOTE_CLK(note1), .GATE(gate1), .ACTIVE_VOICE(av1)
   );

   // Sustain variant: gate held until the next step.
   drum_voice_tone_gen #(.GATE_CYCLES(0), .ARP_CYCLES(ARP_T), .OCTAVE_SHIFT(8)) dut_sus (
      .CLK(CLK), .RESET(RESET), .STEP_EN(STEP_EN), .VOICE(VOICE), .OCTAVE_UP(OCTAVE_UP),
      .NOTE_CLK(note2), .GATE(gate2), .ACTIVE_VOICE(av2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called on a negedge; afterwards idx 0 is the negedge right after the step edge.
   task automatic step(input logic [4:0] v);
      STEP_EN = 1'b1;
      VOICE   = v;
      @(negedge CLK);
      STEP_EN = 1'b0;
      idx     = 0;
   endtask

   task automatic tick_to(input int target);
      while (idx < target) begin
         @(negedge CLK);
         idx++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout, expected run to complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b1; STEP_EN = 1'b0; VOICE = '0; OCTAVE_UP = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_gate", gate1, 0);
      check("rst_note", note1, 0);
      check("rst_av", av1, 0);
      check("rst_gate_sus", gate2, 0);
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      step(5'b00000);
      check("idle_empty_step", gate1, 0);

      // Single voice A, base octave
      step(5'b10000);
      check("a_gate_on", gate1, 1);
      check("a_av", av1, 5'b10000);
      check("a_note_start", note1, 0);
      tick_to(HP_A8 - 1);   check("a_pre_rise", note1, 0);
      tick_to(HP_A8);       check("a_rise", note1, 1);
      tick_to(2*HP_A8 - 1); check("a_pre_fall", note1, 1);
      tick_to(2*HP_A8);     check("a_fall", note1, 0);
      tick_to(3*HP_A8);     check("a_rise2", note1, 1);
      tick_to(2500);        check("a_single_no_arp", av1, 5'b10000);
      tick_to(GATE_T - 1);  check("a_gate_last", gate1, 1);
      tick_to(GATE_T);
      check("a_gate_off", gate1, 0);
      check("a_av_off", av1, 0);
      check("a_note_off", note1, 0);

      // Octave up; drop OCTAVE_UP mid-half-period, it only takes effect at the next reload
      OCTAVE_UP = 1'b1;
      step(5'b10000);
      tick_to(HP_A9 - 1);   check("oct_pre_rise", note1, 0);
      tick_to(HP_A9);       check("oct_rise", note1, 1);
      tick_to(2*HP_A9 - 1); check("oct_pre_fall", note1, 1);
      tick_to(2*HP_A9);     check("oct_fall", note1, 0);
      tick_to(400);
      OCTAVE_UP = 1'b0;
      tick_to(3*HP_A9 - 1);         check("oct_keep_half_lo", note1, 0);
      tick_to(3*HP_A9);             check("oct_keep_half_rise", note1, 1);
      tick_to(3*HP_A9 + HP_A8 - 1); check("oct_new_half_hi", note1, 1);
      tick_to(3*HP_A9 + HP_A8);     check("oct_new_half_fall", note1, 0);
      tick_to(3*HP_A9 + 2*HP_A8);   check("oct_new_rise", note1, 1);

      // Empty step during PLAY stops the note
      tick_to(1310); check("stop_pre_note", note1, 1);
      step(5'b00000);
      check("stop_gate", gate1, 0);
      check("stop_note", note1, 0);
      check("stop_av", av1, 0);
      check("stop_gate_sus", gate2, 0);
      tick_to(1000);
      check("stop_stays_idle", gate1, 0);
      check("stop_note_quiet", note1, 0);

      // Arpeggio B, D, E
      step(5'b01011);
      check("arp_av_b", av1, 5'b01000);
      check("arp_av_b_sus", av2, 5'b01000);
      tick_to(HP_B8 - 1);          check("arp_b_pre_rise", note1, 0);
      tick_to(HP_B8);              check("arp_b_rise", note1, 1);
      tick_to(2*HP_B8);            check("arp_b_fall", note1, 0);
      tick_to(ARP_T - 1);          check("arp_b_last", av1, 5'b01000);
      tick_to(ARP_T);
      check("arp_av_d", av1, 5'b00010);
      check("arp_d_note_start", note1, 0);
      tick_to(ARP_T + HP_D8 - 1);  check("arp_d_pre_rise", note1, 0);
      tick_to(ARP_T + HP_D8);      check("arp_d_rise", note1, 1);
      tick_to(ARP_T + 2*HP_D8);    check("arp_d_fall", note1, 0);
      tick_to(2*ARP_T - 1);
      check("arp_d_last", av1, 5'b00010);
      check("arp_gate_last", gate1, 1);
      tick_to(2*ARP_T);
      check("expiry_beats_arp_gate", gate1, 0);
      check("expiry_beats_arp_av", av1, 0);
      check("arp_av_e_sus", av2, 5'b00001);
      check("arp_e_note_start_sus", note2, 0);
      tick_to(2*ARP_T + HP_E8);    check("arp_e_rise_sus", note2, 1);
      tick_to(3*ARP_T - 1);
      check("arp_e_last_note_sus", note2, 1);
      check("arp_e_last_av_sus", av2, 5'b00001);
      tick_to(3*ARP_T);
      check("arp_wrap_av_sus", av2, 5'b01000);
      check("arp_wrap_note_sus", note2, 0);
      tick_to(3*ARP_T + HP_B8);    check("arp_wrap_rise_sus", note2, 1);

      // Restart mid-note: new voice, gate count and phase restart
      step(5'b00100);
      tick_to(500); check("rs_c_note_hi", note1, 1);
      step(5'b00001);
      check("rs_av", av1, 5'b00001);
      check("rs_note_low", note1, 0);
      check("rs_gate", gate1, 1);
      tick_to(HP_E8 - 1);  check("rs_e_pre_rise", note1, 0);
      tick_to(HP_E8);      check("rs_e_rise", note1, 1);
      tick_to(GATE_T - 500); check("rs_gate_past_old", gate1, 1);
      tick_to(GATE_T - 1); check("rs_gate_last", gate1, 1);
      tick_to(GATE_T);     check("rs_gate_off", gate1, 0);

      // Step on the exact gate-expiry cycle
      step(5'b00010);
      tick_to(GATE_T - 1); check("ex_gate_last", gate1, 1);
      step(5'b01000);
      check("ex_gate_held", gate1, 1);
      check("ex_av", av1, 5'b01000);
      check("ex_note_low", note1, 0);
      tick_to(HP_B8);      check("ex_b_rise", note1, 1);
      tick_to(GATE_T - 1); check("ex_gate_new_last", gate1, 1);
      tick_to(GATE_T);     check("ex_gate_new_off", gate1, 0);

      // Sustain: gate held long past GATE_T
      step(5'b00010);
      tick_to(4750);
      check("sus_ref_gate_off", gate1, 0);
      check("sus_gate", gate2, 1);
      check("sus_av", av2, 5'b00010);
      check("sus_note", note2, 1);

      // Asynchronous reset mid-note
      step(5'b10000);
      tick_to(400);
      check("ar_pre_note", note1, 1);
      check("ar_pre_gate", gate1, 1);
      RESET = 1'b1;
      #1;
      check("ar_gate", gate1, 0);
      check("ar_note", note1, 0);
      check("ar_av", av1, 0);
      check("ar_gate_sus", gate2, 0);
      check("ar_note_sus", note2, 0);
      check("ar_av_sus", av2, 0);
      repeat (3) @(negedge CLK);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);
      check("ar_idle_after", gate1, 0);
      step(5'b00001);
      check("ar_replay_gate", gate1, 1);
      check("ar_replay_av", av1, 5'b00001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
